// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesting engines and the round-robin arbiter.
//   master : requester side, drives req/done, observes the grant outputs
//   slave  : arbiter side, observes req/done, drives the grant outputs
// Signals:
//   req       [N-1:0] request vector, bit i = requester i wants the resource
//   done              release strobe from the current owner
//   gnt       [N-1:0] one-hot grant
//   gnt_id    [W-1:0] binary index of the current owner
//   gnt_valid         a grant is held
//   busy              arbiter is in GRANT or RELEASE
//   timeout           one-cycle pulse on a forced release
interface rr_arbiter_if #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
);
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic [W-1:0] gnt_id;
    logic         gnt_valid;
    logic         busy;
    logic         timeout;

    modport master (
        output req, done,
        input  gnt, gnt_id, gnt_valid, busy, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, gnt_valid, busy, timeout
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter sharing one downstream resource among N requesters.
// The grant is held until the owner strobes done or drops its request, then
// one RELEASE bubble and one IDLE decision cycle separate consecutive grants.
// The previous owner gets the lowest priority in the next search.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  rr_arbiter_if.slave (req, done in; gnt, gnt_id, gnt_valid, busy,
//        timeout out; all outputs registered)
// Optional: define ARB_TIMEOUT_EN to force-release a grant held for MAX_HOLD
// GRANT cycles and pulse timeout; otherwise timeout is tied 0.
module rr_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned W        = 3,
    parameter int unsigned MAX_HOLD = 16
) (
    input logic          clk,
    input logic          rst,
    rr_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic [W-1:0] gnt_id_q, gnt_id_d;
    logic [W-1:0] last_id_q, last_id_d;
    logic         gnt_valid_q, gnt_valid_d;
    logic         busy_q, busy_d;

    logic [N-1:0] rot_c;
    logic [W-1:0] hi_c;
    logic [W-1:0] win_id_c;
    logic         norm_rel_c;
    logic         force_rel_c;

    // (base + 1 + off) mod N, with base < N and off < N
    function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base,
                                              input int unsigned off);
        int unsigned s;
        s = 32'(base) + 32'd1 + off;
        if (s >= N) begin
            s = s - N;
        end
        return W'(s);
    endfunction

    // Rotate so the first index in search order (last_id+1) lands on the MSB
    always_comb begin
        rot_c = '0;
        for (int unsigned k = 0; k < N; k++) begin
            rot_c[N-1-k] = bus.req[wrap_add(last_id_q, k)];
        end
    end

    // Highest-index-wins encoder, then map the rotated position back
    always_comb begin
        hi_c = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (rot_c[k]) begin
                hi_c = W'(k);
            end
        end
        win_id_c = wrap_add(last_id_q, N - 32'd1 - 32'(hi_c));
    end

    assign norm_rel_c = (state_q == GRANT) && (bus.done || !bus.req[gnt_id_q]);

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;

    // Hold counter: cleared outside GRANT, forces release on reaching MAX_HOLD
    always_comb begin
        hold_d      = '0;
        timeout_d   = 1'b0;
        force_rel_c = 1'b0;
        if (state_q == GRANT && !norm_rel_c) begin
            if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                force_rel_c = 1'b1;
                timeout_d   = 1'b1;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    // MAX_HOLD only sizes the hold counter, which is not built here
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD == 0);
    assign force_rel_c     = 1'b0;
    assign bus.timeout     = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        last_id_d   = last_id_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d     = GRANT;
                    gnt_d       = N'(1) << win_id_c;
                    gnt_id_d    = win_id_c;
                    gnt_valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (norm_rel_c || force_rel_c) begin
                    state_d     = RELEASE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    last_id_d   = gnt_id_q;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            last_id_q   <= W'(N - 1);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            busy_q      <= busy_d;
            last_id_q   <= last_id_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: a cycle model built from the arbitration
// rules (owner / last owner / bubble count) checked every cycle, plus directed
// vectors with hand-computed grants.
module tb_rr_arbiter;
    localparam int unsigned N = 8;
    localparam int unsigned W = 3;
`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TB_HOLD = 4;
    localparam bit          TO_EN   = 1'b1;
`else
    localparam int unsigned TB_HOLD = 16;
    localparam bit          TO_EN   = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_arbiter_if #(.N(N), .W(W)) bus ();

    rr_arbiter #(.N(N), .W(W), .MAX_HOLD(TB_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner (-1 = none), last owner, bubble cycles left, GRANT cycles held
    int   m_owner = -1;
    int   m_last  = N - 1;
    int   m_cool  = 0;
    int   m_held  = 0;
    int   m_cand;
    logic m_tout  = 1'b0;
    bit   armed   = 1'b0;
    bit   m_norm;

    always @(posedge clk) begin
        m_tout = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_last  = N - 1;
            m_cool  = 0;
            m_held  = 0;
            armed   = 1'b1;
        end else if (m_owner >= 0) begin
            m_held = m_held + 1;
            m_norm = bus.done || !bus.req[m_owner];
            if (m_norm || (TO_EN && m_held == TB_HOLD)) begin
                m_tout  = !m_norm;
                m_last  = m_owner;
                m_owner = -1;
                m_cool  = 1;
            end
        end else if (m_cool > 0) begin
            m_cool = m_cool - 1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                m_cand = (m_last + k) % N;
                if (m_owner < 0 && bus.req[m_cand]) begin
                    m_owner = m_cand;
                    m_held  = 0;
                end
            end
        end
    end

    logic [N-1:0] e_gnt;
    always @(negedge clk) begin
        if (armed) begin
            e_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            cmp("model_gnt", 32'(bus.gnt), 32'(e_gnt));
            cmp("model_gnt_id", 32'(bus.gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            cmp("model_gnt_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
            cmp("model_busy", 32'(bus.busy), 32'(m_owner >= 0 || m_cool > 0));
            cmp("model_timeout", 32'(bus.timeout), 32'(m_tout));
        end
    end

    // Apply inputs at a falling edge and advance to the next falling edge
    task automatic drv(input logic [N-1:0] r, input logic d);
        bus.req  = r;
        bus.done = d;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [N-1:0] g, input int unsigned id,
                       input logic b);
        cmp({name, "_gnt"}, 32'(bus.gnt), 32'(g));
        cmp({name, "_id"}, 32'(bus.gnt_id), id);
        cmp({name, "_valid"}, 32'(bus.gnt_valid), 32'(g != '0));
        cmp({name, "_busy"}, 32'(bus.busy), 32'(b));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        bus.req  = '1;
        bus.done = 1'b0;
        @(negedge clk);

        // Reset with all requesting
        drv(8'hFF, 1'b0); chk("rst", 8'h00, 0, 1'b0);
        rst = 1'b0;
        drv(8'hFF, 1'b0); chk("first", 8'h01, 0, 1'b1);

        // Full rotation with done pulses: 1,2,...,7,0, two zero cycles between grants
        for (int i = 1; i <= 8; i++) begin
            drv(8'hFF, 1'b1); chk("rot_rel", 8'h00, 0, 1'b1);
            drv(8'hFF, 1'b0); chk("rot_idle", 8'h00, 0, 1'b0);
            drv(8'hFF, 1'b0); chk("rot_gnt", N'(1) << (i % 8), i % 8, 1'b1);
        end

        // Owner 3 keeps its request while others appear; then done, 7 wins
        drv(8'h08, 1'b1); chk("o3_rel0", 8'h00, 0, 1'b1);
        drv(8'h08, 1'b0);
        drv(8'h08, 1'b0); chk("o3_gnt", 8'h08, 3, 1'b1);
        drv(8'h89, 1'b0); chk("o3_hold", 8'h08, 3, 1'b1);
        drv(8'h89, 1'b1); chk("o3_rel", 8'h00, 0, 1'b1);
        drv(8'h81, 1'b0); chk("o3_idle", 8'h00, 0, 1'b0);
        drv(8'h81, 1'b0); chk("o3_next", 8'h80, 7, 1'b1);

        // Owner 5 drops its request: release, last owner becomes 5
        drv(8'h20, 1'b1);
        drv(8'h20, 1'b0);
        drv(8'h20, 1'b0); chk("o5_gnt", 8'h20, 5, 1'b1);
        drv(8'h00, 1'b0); chk("o5_drop", 8'h00, 0, 1'b1);
        drv(8'h00, 1'b0); chk("o5_idle", 8'h00, 0, 1'b0);
        drv(8'h41, 1'b0); chk("o5_after", 8'h40, 6, 1'b1);

        // Owner 4 regranted as sole requester, then reset mid-grant
        drv(8'h10, 1'b1);
        drv(8'h10, 1'b0);
        drv(8'h10, 1'b0); chk("o4_gnt", 8'h10, 4, 1'b1);
        drv(8'h10, 1'b1);
        drv(8'h10, 1'b0);
        drv(8'h10, 1'b0); chk("regrant", 8'h10, 4, 1'b1);
        rst = 1'b1;
        drv(8'h30, 1'b0); chk("midrst", 8'h00, 0, 1'b0);
        rst = 1'b0;
        drv(8'h30, 1'b0); chk("postrst", 8'h10, 4, 1'b1);

        // done outside GRANT is ignored
        drv(8'h00, 1'b1); chk("d_rel", 8'h00, 0, 1'b1);
        drv(8'h00, 1'b1);
        drv(8'h00, 1'b1); chk("d_idle", 8'h00, 0, 1'b0);
        drv(8'h02, 1'b1); chk("d_gnt", 8'h02, 1, 1'b1);
        drv(8'h02, 1'b0); chk("d_hold", 8'h02, 1, 1'b1);

        // Owner 2 holds its request with no done
        drv(8'h04, 1'b1);
        drv(8'h04, 1'b0);
        drv(8'h04, 1'b0); chk("o2_gnt", 8'h04, 2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drv(8'h04, 1'b0); chk("o2_hold", 8'h04, 2, 1'b1);
            cmp("o2_no_timeout", 32'(bus.timeout), 32'd0);
        end
`ifdef ARB_TIMEOUT_EN
        drv(8'h04, 1'b0); chk("to_rel", 8'h00, 0, 1'b1);
        cmp("to_pulse", 32'(bus.timeout), 32'd1);
        drv(8'h04, 1'b0); chk("to_idle", 8'h00, 0, 1'b0);
        cmp("to_pulse_end", 32'(bus.timeout), 32'd0);
        drv(8'h04, 1'b0); chk("to_regrant", 8'h04, 2, 1'b1);
`else
        for (int i = 0; i < 20; i++) begin
            drv(8'h04, 1'b0);
        end
        chk("o2_long_hold", 8'h04, 2, 1'b1);
        cmp("o2_timeout_tied", 32'(bus.timeout), 32'd0);
`endif
        drv(8'h00, 1'b0);
        drv(8'h00, 1'b0);
        drv(8'h00, 1'b0); chk("end_idle", 8'h00, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
